// File: rtl/alu_pkg.sv
// Shared constants for the 16-bit sequencer that drives the 8-bit ALU:
// ALU op codes, command encodings, FSM state codes and the cmd->op mapping.
package alu_pkg;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_XOR    = 3'b011;
  localparam logic [2:0] ALU_PASS_B = 3'b100;
  localparam logic [2:0] ALU_ADD_NF = 3'b101;

  localparam logic [1:0] CMD_ADD16 = 2'b00;
  localparam logic [1:0] CMD_AND16 = 2'b01;
  localparam logic [1:0] CMD_XOR16 = 2'b10;
  localparam logic [1:0] CMD_MOV16 = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LO   = 3'd1;
  localparam logic [2:0] ST_HI   = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_INC  = 3'd4;
  localparam logic [2:0] ST_INCW = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  function automatic logic [2:0] cmd_to_op(input logic [1:0] c);
    logic [2:0] op;
    case (c)
      CMD_ADD16: op = ALU_ADD;
      CMD_AND16: op = ALU_AND;
      CMD_XOR16: op = ALU_XOR;
      default:   op = ALU_PASS_B;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_seq16.sv
// Sequences a 16-bit ADD/AND/XOR/MOV as byte operations on a registered 8-bit ALU
// and presents the assembled result with carry/zero flags on a one-cycle done pulse.
module alu_seq16
  import alu_pkg::*;
#(
  parameter bit         CARRY_EN = 1'b1,
  parameter logic [2:0] IDLE_OP  = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_res,
  input  logic        alu_ovf,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero
);

  // Handshake: start is only looked at in IDLE; done marks the single cycle in
  // which result/carry/zero are fresh, and they stay put until the next done.

  logic [2:0]  state;
  logic [1:0]  cmd_q;
  logic [15:0] opa_q;
  logic [15:0] opb_q;
  logic [15:0] work;
  logic        c_lo;
  logic        c_hi;
  logic        is_add;

  assign is_add = (cmd_q == CMD_ADD16);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cmd_q  <= CMD_ADD16;
      opa_q  <= 16'h0000;
      opb_q  <= 16'h0000;
      work   <= 16'h0000;
      c_lo   <= 1'b0;
      c_hi   <= 1'b0;
      result <= 16'h0000;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cmd_q <= cmd;
            opa_q <= opa;
            opb_q <= opb;
            state <= ST_LO;
          end
        end
        ST_LO: state <= ST_HI;
        ST_HI: begin
          work[7:0] <= alu_res;
          c_lo      <= is_add & alu_ovf;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          work[15:8] <= alu_res;
          c_hi       <= is_add & alu_ovf;
          if (is_add && (CARRY_EN != 1'b0) && c_lo) begin
            state <= ST_INC;
          end else begin
            // Outputs load on entry to DONE so an in-flight command never disturbs them.
            result <= {alu_res, work[7:0]};
            carry  <= is_add & alu_ovf;
            zero   <= ({alu_res, work[7:0]} == 16'h0000);
            state  <= ST_DONE;
          end
        end
        ST_INC: state <= ST_INCW;
        ST_INCW: begin
          work[15:8] <= alu_res;
          c_hi       <= c_hi | alu_ovf;
          result     <= {alu_res, work[7:0]};
          carry      <= c_hi | alu_ovf;
          zero       <= ({alu_res, work[7:0]} == 16'h0000);
          state      <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_op = IDLE_OP;
    alu_a  = 8'h00;
    alu_b  = 8'h00;
    case (state)
      ST_LO: begin
        alu_op = cmd_to_op(cmd_q);
        alu_a  = opa_q[7:0];
        alu_b  = opb_q[7:0];
      end
      ST_HI: begin
        alu_op = cmd_to_op(cmd_q);
        alu_a  = opa_q[15:8];
        alu_b  = opb_q[15:8];
      end
      ST_INC: begin
        alu_op = ALU_ADD;
        alu_a  = work[15:8];
        alu_b  = 8'h01;
      end
      default: begin
        alu_op = IDLE_OP;
        alu_a  = 8'h00;
        alu_b  = 8'h00;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: two sequencers (carry chain on/off), each next to a
// behavioural registered 8-bit ALU, with expected-result queues and monitors.
module tb_alu_seq16;
  import alu_pkg::*;

  localparam int W = 50;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shared stimulus ----------------
  logic [1:0]  cmd_s;
  logic [15:0] opa_s;
  logic [15:0] opb_s;
  logic        start0;
  logic        start1;

  // ---------------- DUT 0 (CARRY_EN=1) + ALU ----------------
  logic [2:0]  alu_op0;
  logic [7:0]  alu_a0, alu_b0;
  logic [7:0]  alu_res0 = 8'h00;
  logic        alu_ovf0 = 1'b0;
  logic        busy0, done0, carry0, zero0;
  logic [15:0] result0;

  alu_seq16 #(.CARRY_EN(1'b1), .IDLE_OP(3'b000)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .cmd(cmd_s), .opa(opa_s), .opb(opb_s),
    .alu_op(alu_op0), .alu_a(alu_a0), .alu_b(alu_b0),
    .alu_res(alu_res0), .alu_ovf(alu_ovf0),
    .busy(busy0), .done(done0), .result(result0), .carry(carry0), .zero(zero0)
  );

  always @(posedge clk) begin
    case (alu_op0)
      ALU_ADD:    {alu_ovf0, alu_res0} <= {1'b0, alu_a0} + {1'b0, alu_b0};
      ALU_AND:    alu_res0 <= alu_a0 & alu_b0;
      ALU_XOR:    alu_res0 <= alu_a0 ^ alu_b0;
      ALU_PASS_B: alu_res0 <= alu_b0;
      ALU_ADD_NF: alu_res0 <= alu_a0 + alu_b0;
      default:    alu_res0 <= alu_a0;
    endcase
  end

  // ---------------- DUT 1 (CARRY_EN=0) + ALU ----------------
  logic [2:0]  alu_op1;
  logic [7:0]  alu_a1, alu_b1;
  logic [7:0]  alu_res1 = 8'h00;
  logic        alu_ovf1 = 1'b0;
  logic        busy1, done1, carry1, zero1;
  logic [15:0] result1;

  alu_seq16 #(.CARRY_EN(1'b0), .IDLE_OP(3'b000)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cmd(cmd_s), .opa(opa_s), .opb(opb_s),
    .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_res(alu_res1), .alu_ovf(alu_ovf1),
    .busy(busy1), .done(done1), .result(result1), .carry(carry1), .zero(zero1)
  );

  always @(posedge clk) begin
    case (alu_op1)
      ALU_ADD:    {alu_ovf1, alu_res1} <= {1'b0, alu_a1} + {1'b0, alu_b1};
      ALU_AND:    alu_res1 <= alu_a1 & alu_b1;
      ALU_XOR:    alu_res1 <= alu_a1 ^ alu_b1;
      ALU_PASS_B: alu_res1 <= alu_b1;
      ALU_ADD_NF: alu_res1 <= alu_a1 + alu_b1;
      default:    alu_res1 <= alu_a1;
    endcase
  end

  // ---------------- scoreboard ----------------
  // Entry: {expected done cycle[31:0], result[15:0], carry, zero}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && done0) begin
      if (exp_q.size() == 0) begin
        check("dut0_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dut0_done_cycle", cyc, e[49:18]);
        check("dut0_result", {16'h0, result0}, {16'h0, e[17:2]});
        check("dut0_carry", {31'h0, carry0}, {31'h0, e[1]});
        check("dut0_zero", {31'h0, zero0}, {31'h0, e[0]});
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && done1) begin
      if (exp1_q.size() == 0) begin
        check("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp1_q.pop_front();
        check("dut1_done_cycle", cyc, e[49:18]);
        check("dut1_result", {16'h0, result1}, {16'h0, e[17:2]});
        check("dut1_carry", {31'h0, carry1}, {31'h0, e[1]});
        check("dut1_zero", {31'h0, zero1}, {31'h0, e[0]});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue0(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                        input int lat, input logic [15:0] r, input logic cy, input logic z);
    int due;
    cmd_s  = c;
    opa_s  = a;
    opb_s  = b;
    start0 = 1'b1;
    due = cyc + lat;
    exp_q.push_back({due[31:0], r, cy, z});
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    cmd_s  = 2'b00;
    opa_s  = 16'h0;
    opb_s  = 16'h0;
    cyc    = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy0}, 32'd0);
    check("rst_done", {31'h0, done0}, 32'd0);
    check("rst_result", {16'h0, result0}, 32'd0);
    check("rst_carry", {31'h0, carry0}, 32'd0);
    check("rst_zero", {31'h0, zero0}, 32'd0);
    check("rst_alu_op", {29'h0, alu_op0}, 32'd0);
    check("rst_alu_a", {24'h0, alu_a0}, 32'd0);
    check("rst_alu_b", {24'h0, alu_b0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // INC path: low byte carries into high byte
    issue0(CMD_ADD16, 16'h12FF, 16'h0001, 6, 16'h1300, 1'b0, 1'b0);
    wait_done0("timeout_add_12ff");
    @(negedge clk);
    issue0(CMD_ADD16, 16'hFFFF, 16'h0001, 6, 16'h0000, 1'b1, 1'b1);
    wait_done0("timeout_add_ffff");
    @(negedge clk);
    // High-byte carry leaves the ALU flag at 1 for the following logic ops
    issue0(CMD_ADD16, 16'h8000, 16'h8000, 4, 16'h0000, 1'b1, 1'b1);
    wait_done0("timeout_add_8000");
    @(negedge clk);
    issue0(CMD_XOR16, 16'hAAAA, 16'hAAAA, 4, 16'h0000, 1'b0, 1'b1);
    wait_done0("timeout_xor");
    @(negedge clk);
    issue0(CMD_AND16, 16'hF0F0, 16'h0FF0, 4, 16'h00F0, 1'b0, 1'b0);
    wait_done0("timeout_and");
    @(negedge clk);

    // MOV with a stray start while busy, then a back-to-back ADD
    issue0(CMD_MOV16, 16'hFFFF, 16'h1234, 4, 16'h1234, 1'b0, 1'b0);
    cmd_s  = CMD_ADD16;
    opa_s  = 16'h0;
    opb_s  = 16'h0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0("timeout_mov");
    @(negedge clk);
    issue0(CMD_ADD16, 16'h1111, 16'h2222, 4, 16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    check("held_result_busy", {31'h0, busy0}, 32'd1);
    check("held_result", {16'h0, result0}, 32'h1234);
    wait_done0("timeout_b2b");
    @(negedge clk);

    // Reset while in HI aborts with no done pulse
    cmd_s  = CMD_ADD16;
    opa_s  = 16'h5555;
    opb_s  = 16'h5555;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", {31'h0, busy0}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'h0, busy0}, 32'd0);
    check("abort_done", {31'h0, done0}, 32'd0);
    check("abort_result", {16'h0, result0}, 32'd0);
    check("abort_carry", {31'h0, carry0}, 32'd0);
    repeat (8) @(negedge clk);
    issue0(CMD_ADD16, 16'h0001, 16'h0001, 4, 16'h0002, 1'b0, 1'b0);
    wait_done0("timeout_add_0001");
    @(negedge clk);

    // Independent byte adds: low-byte carry is dropped
    begin
      int due;
      bit seen = 1'b0;
      cmd_s  = CMD_ADD16;
      opa_s  = 16'h00FF;
      opb_s  = 16'h0001;
      start1 = 1'b1;
      due = cyc + 4;
      exp1_q.push_back({due[31:0], 16'h0000, 1'b0, 1'b1});
      @(negedge clk);
      start1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done1) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) check("timeout_dut1", 32'd0, 32'd1);
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("exp1_q_drained", exp1_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq16.md
Name: alu_seq16

Overview:
- Initiator side of the 8-bit ALU interface.
- Drives the op, in_a and in_b ports of the ALU.
- Consumes its registered alu_out and OVF_out one cycle after each issue.
- Runs 16-bit ADD/AND/XOR/MOV as a sequence of byte operations and returns a 16-bit result with carry and zero flags to the control unit.

Parameters:
- CARRY_EN, 1: 1 propagates the low-byte carry into the high byte on ADD16; 0 gives independent byte adds, no INC states.
- IDLE_OP, 3'b000: op driven whenever no issue is in flight. Pass-A leaves the ALU overflow flag untouched.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  command request, sampled only in IDLE
- cmd  in  2  00 ADD16, 01 AND16, 10 XOR16, 11 MOV16 (result = opb)
- opa  in  16  operand A
- opb  in  16  operand B
- alu_op  out  3  to ALU op
- alu_a  out  8  to ALU in_a
- alu_b  out  8  to ALU in_b
- alu_res  in  8  from ALU alu_out
- alu_ovf  in  1  from ALU OVF_out
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result, carry and zero are valid in that cycle and held afterwards
- result  out  16  assembled result
- carry  out  1  ADD16 carry out; 0 for all other commands
- zero  out  1  result == 16'h0000

Behaviour:
- Clocking and reset:
  - Single clock, clk; reset is synchronous and active-high, rst.
  - rst clears state to IDLE; busy=0, done=0, result=0, carry=0, zero=0, alu_op=IDLE_OP, alu_a=0, alu_b=0.
  - Reset mid-operation aborts with no done pulse. ALU contents are don't-care after reset; they are never sampled outside capture states.
- ALU op mapping (ADD16/AND16/XOR16/MOV16):
  - ADD16 → 001, the flag-updating add.
  - AND16 → 010.
  - XOR16 → 011.
  - MOV16 → 100, pass B.
  - Ops 101/110/111 are never issued.
- Operand latch: on the IDLE edge with start=1, latch cmd, opa and opb. Start while busy is ignored.
- States:
  - IDLE: drive IDLE_OP, alu_a=0, alu_b=0. On start → LO.
  - LO: issue op with opa[7:0], opb[7:0]. → HI.
  - HI: issue op with opa[15:8], opb[15:8]. Capture result[7:0]=alu_res and c_lo=alu_ovf; c_lo is forced to 0 unless ADD16. → WAIT.
  - WAIT: drive IDLE_OP. Capture result[15:8]=alu_res and c_hi=alu_ovf, masked to ADD16.
    - If ADD16 && CARRY_EN && c_lo → INC.
    - Otherwise → DONE.
  - INC: issue 001 with alu_a=result[15:8], alu_b=8'h01. → INCW.
  - INCW: drive IDLE_OP. Capture result[15:8]=alu_res; c_hi |= alu_ovf. → DONE.
  - DONE: done=1; carry=c_hi; zero=(result==0). → IDLE.
- Latency: done is high 4 cycles after the start-sampling edge, or 6 cycles when INC is taken. busy falls the cycle after done.
- A new start is accepted in the IDLE cycle right after DONE; it must not disturb the displayed result until its own DONE.
- alu_ovf is only sampled in the capture state following an op-001 issue. The ALU flag is stale otherwise.
- Two carries cannot both occur in one ADD16 (INC runs only when the high sum ≤ 0xFE+carry path); the OR of c_hi is still required.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants: ALU_PASS_A=000, ALU_ADD=001, ALU_AND=010, ALU_XOR=011, ALU_PASS_B=100, ALU_ADD_NF=101.
  - cmd encodings.
  - State enum: IDLE, LO, HI, WAIT, INC, INCW, DONE.
- No sub-module. The bench instantiates the existing ALU next to alu_seq16.

Test Plan:
- ADD16 0x12FF+0x0001 → result 0x1300, carry 0, zero 0; INC taken; done 6 cycles after start.
- ADD16 0xFFFF+0x0001 → result 0x0000, carry 1 (from INC), zero 1.
- ADD16 0x8000+0x8000 → result 0x0000, carry 1 (high byte), zero 1, done at 4 cycles. Repeat with CARRY_EN=0 on 0x00FF+0x0001 → 0x0000, carry 0.
- AND16 0xF0F0&0x0FF0 → 0x00F0, carry 0, done at 4 cycles. XOR16 0xAAAA^0xAAAA → 0x0000, zero 1. A prior stale ALU OVF=1 must not set carry.
- MOV16 opb=0x1234 → 0x1234. A second start asserted during busy is ignored; back-to-back start in the cycle after done is accepted.
- rst pulsed while in HI → next cycle busy=0, done never pulses, result=0. A following ADD16 0x0001+0x0001 → 0x0002 at 4 cycles.
